// File: rtl/display_sequencer.sv
// display_sequencer: snapshots four BCD digits, the colon flag and the brightness
// setting. It then sends a 7-byte refresh frame to the serial byte transmitter,
// one byte per tx_valid/tx_ready handshake.
module display_sequencer #(
  parameter int unsigned REFRESH_CYCLES = 5_000_000,
  parameter int unsigned ACK_TIMEOUT    = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        colon,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  input  logic        update,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned RefW    = $clog2(REFRESH_CYCLES);
  localparam int unsigned ToW     = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned LastIdx = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_NEXT
  } state_e;

  state_e          state_q;
  logic [RefW-1:0] refresh_q;
  logic            refresh_wrap;
  logic            pending_q;
  logic            pending_set;
  logic [2:0]      idx_q;
  logic [ToW-1:0]  to_q;
  logic [15:0]     digits_q;
  logic            colon_q;
  logic [2:0]      bright_q;
  logic            on_q;
  logic            tx_valid_q;
  logic [7:0]      tx_data_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            err_q;
  logic [7:0]      byte_c;

  // BCD digit to gfedcba segment pattern; codes above 9 are blanked
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign refresh_wrap = (refresh_q == RefW'(REFRESH_CYCLES - 1));
  assign pending_set  = update | refresh_wrap;

  // Free-running refresh period counter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      refresh_q <= '0;
    end else if (refresh_wrap) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_q + RefW'(1);
    end
  end

  // Frame byte selected by the current index from the snapshot
  always_comb begin
    byte_c = 8'h00;
    case (idx_q)
      3'd0:    byte_c = 8'h40;
      3'd1:    byte_c = 8'hC0;
      3'd2:    byte_c = {1'b0, seg7(digits_q[3:0])};
      3'd3:    byte_c = {colon_q, seg7(digits_q[7:4])};
      3'd4:    byte_c = {1'b0, seg7(digits_q[11:8])};
      3'd5:    byte_c = {1'b0, seg7(digits_q[15:12])};
      3'd6:    byte_c = {4'b1000, on_q, bright_q};
      default: byte_c = 8'h00;
    endcase
  end

  // Frame sequencer; pending set requests win over the consume in S_IDLE
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      to_q         <= '0;
      digits_q     <= '0;
      colon_q      <= 1'b0;
      bright_q     <= '0;
      on_q         <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      pending_q    <= pending_q | pending_set;
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            pending_q <= pending_set;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          digits_q <= digits;
          colon_q  <= colon;
          bright_q <= brightness;
          on_q     <= display_on;
          idx_q    <= '0;
          state_q  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (tx_ready) begin
            tx_data_q  <= byte_c;
            tx_valid_q <= 1'b1;
            to_q       <= '0;
            state_q    <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!tx_ready) begin
            state_q <= S_WAIT_HIGH;
          end else if (to_q == ToW'(ACK_TIMEOUT - 1)) begin
            // Abort and keep the request so the whole frame is retried
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            pending_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            to_q <= to_q + ToW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (tx_ready) begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_q == 3'(LastIdx)) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
